// File: rtl/addsub_sched_if.sv
// Request/response bundle between NREQ clients and the shared add/sub scheduler.
// master = client side (drives requests, consumes responses), slave = scheduler.
interface addsub_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][31:0] req_a;
  logic [NREQ-1:0][31:0] req_b;
  logic [NREQ-1:0]       req_sub;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [31:0]           rsp_sum;
  logic                  rsp_cout;

  modport master (
    output req_valid, req_a, req_b, req_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/addsub_sched.sv
// Round-robin scheduler sharing one 32-bit add/sub datapath, computed as two
// 16-bit halves on consecutive cycles with the mid carry registered.
module addsub_sched_lane (
  input  logic        sel,
  input  logic        sub,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] a_m,
  output logic [31:0] bx_m,
  output logic        sub_m
);
  // Unselected lanes contribute zeros so the operand mux is a plain OR.
  assign a_m   = sel ? a : '0;
  assign bx_m  = sel ? (sub ? ~b : b) : '0;
  assign sub_m = sel & sub;
endmodule

module addsub_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input logic          clk,
  input logic          rst,
  addsub_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, RESP} state_t;

  state_t                state, state_nx;
  logic [IDW-1:0]        ptr, gnt;
  logic                  found, hs;
  logic [NREQ-1:0]       ready;
  logic [NREQ-1:0][31:0] a_m, bx_m;
  logic [NREQ-1:0]       sub_m;
  logic [31:0]           a_sel, bx_sel;
  logic                  sub_sel;
  logic [31:0]           a_q, bx_q, sum_q;
  logic                  cin_q, c16_q, cout_q, vld_q;
  logic [IDW-1:0]        id_q;

  // Rotating priority: first pass covers ptr..NREQ-1, second pass wraps to 0.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && bus.req_valid[i] && (IDW'(i) >= ptr)) begin
        found = 1'b1;
        gnt   = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && bus.req_valid[i]) begin
        found = 1'b1;
        gnt   = IDW'(i);
      end
    end
  end

  assign hs = (state == IDLE) && found;

  always_comb begin
    ready = '0;
    for (int i = 0; i < NREQ; i++) ready[i] = hs && (gnt == IDW'(i));
  end

  assign bus.req_ready = ready;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    addsub_sched_lane u_lane (
      .sel   (ready[i]),
      .sub   (bus.req_sub[i]),
      .a     (bus.req_a[i]),
      .b     (bus.req_b[i]),
      .a_m   (a_m[i]),
      .bx_m  (bx_m[i]),
      .sub_m (sub_m[i])
    );
  end

  always_comb begin
    a_sel   = '0;
    bx_sel  = '0;
    sub_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      a_sel   = a_sel | a_m[i];
      bx_sel  = bx_sel | bx_m[i];
      sub_sel = sub_sel | sub_m[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (hs) state_nx = LOW;
      LOW:     state_nx = HIGH;
      HIGH:    state_nx = RESP;
      RESP:    if (bus.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= '0;
      a_q    <= '0;
      bx_q   <= '0;
      cin_q  <= 1'b0;
      id_q   <= '0;
      sum_q  <= '0;
      c16_q  <= 1'b0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (hs) begin
          a_q   <= a_sel;
          bx_q  <= bx_sel;
          cin_q <= sub_sel;
          id_q  <= gnt;
          ptr   <= (gnt == IDW'(NREQ-1)) ? '0 : gnt + 1'b1;
        end
        LOW:  {c16_q, sum_q[15:0]} <= {1'b0, a_q[15:0]} + {1'b0, bx_q[15:0]} + {16'b0, cin_q};
        HIGH: begin
          {cout_q, sum_q[31:16]} <= {1'b0, a_q[31:16]} + {1'b0, bx_q[31:16]} + {16'b0, c16_q};
          vld_q <= 1'b1;
        end
        RESP: if (bus.rsp_ready) vld_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // id_q only reloads at the next grant, so it doubles as the response tag.
  assign bus.rsp_valid = vld_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;
endmodule

// File: tb/tb_addsub_sched.sv
// Scoreboard bench for addsub_sched: directed vectors, random ops, fairness,
// backpressure and mid-operation reset.
module tb_addsub_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    sum;
    logic           cout;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  addsub_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus();
  addsub_sched #(.NREQ(NREQ), .IDW(IDW)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t sb[$];
  int   glog[$];
  int   checks = 0, errors = 0, rsp_count = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic [31:0] bx;
    bx = sub ? ~b : b;
    return {1'b0, a} + {1'b0, bx} + {32'b0, sub};
  endfunction

  // Monitor: push expectation at each request handshake, pop at each response.
  always @(negedge clk) begin : mon
    logic [32:0] r;
    exp_t e;
    if (!rst) begin
      chk("ready_onehot", 32'($countones(bus.req_ready) <= 1), 1);
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          r = model(bus.req_a[i], bus.req_b[i], bus.req_sub[i]);
          sb.push_back('{id: IDW'(i), sum: r[31:0], cout: r[32]});
          glog.push_back(i);
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        rsp_count++;
        if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          chk("rsp_id",   32'(bus.rsp_id),   32'(e.id));
          chk("rsp_sum",  bus.rsp_sum,       e.sum);
          chk("rsp_cout", 32'(bus.rsp_cout), 32'(e.cout));
        end
      end
    end
  end

  task automatic drive(input int i, input logic [31:0] a, input logic [31:0] b, input logic sub);
    bus.req_a[i[IDW-1:0]]     = a;
    bus.req_b[i[IDW-1:0]]     = b;
    bus.req_sub[i[IDW-1:0]]   = sub;
    bus.req_valid[i[IDW-1:0]] = 1'b1;
  endtask

  task automatic wait_hs(input int i);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.req_valid[i[IDW-1:0]] && bus.req_ready[i[IDW-1:0]]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("hs_timeout", 32'(ok), 1);
    @(posedge clk); #1;
    bus.req_valid[i[IDW-1:0]] = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 60; n++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic run_vec(input int i, input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [31:0] exp_sum, input logic exp_cout);
    int n;
    drive(i, a, b, sub);
    wait_hs(i);
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        n = k;
        break;
      end
    end
    chk("latency",  n, 3);
    chk("vec_sum",  bus.rsp_sum, exp_sum);
    chk("vec_cout", 32'(bus.rsp_cout), 32'(exp_cout));
    chk("vec_id",   32'(bus.rsp_id), i);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int   fexp[9] = '{0, 1, 2, 3, 0, 1, 3, 1, 3};
    int   n0, sel;
    logic ok, s;

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sub   = '0;
    bus.rsp_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_id",    32'(bus.rsp_id),    0);
    chk("rst_rsp_sum",   bus.rsp_sum,        0);
    chk("rst_rsp_cout",  32'(bus.rsp_cout),  0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_vec(0, 32'd5,          32'd3, 1'b0, 32'h0000_0008, 1'b0);
    run_vec(1, 32'd3,          32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0);
    run_vec(2, 32'd5,          32'd3, 1'b1, 32'h0000_0002, 1'b1);
    run_vec(3, 32'h0000_FFFF,  32'd1, 1'b0, 32'h0001_0000, 1'b0);
    run_vec(0, 32'hFFFF_FFFF,  32'd1, 1'b0, 32'h0000_0000, 1'b1);

    for (int k = 0; k < 8; k++) begin
      sel = int'($urandom_range(0, NREQ-1));
      s   = 1'($urandom_range(0, 1));
      drive(sel, $urandom, $urandom, s);
      wait_hs(sel);
      wait_drain();
    end

    // Fairness: all valid from reset, then only 1 and 3 once ptr reaches 2.
    rst = 1'b1;
    sb.delete();
    glog.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) drive(i, 32'(i * 7 + 1), 32'(i), 1'b0);
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (glog.size() >= 6 && glog.size() < 9) bus.req_valid = 4'b1010;
      if (glog.size() >= 9) break;
    end
    bus.req_valid = '0;
    chk("fair_count", glog.size(), 9);
    for (int k = 0; k < 9; k++)
      if (k < glog.size()) chk("fair_grant", glog[k], fexp[k]);
    wait_drain();

    // Backpressure: response must stay frozen while rsp_ready is low.
    bus.rsp_ready = 1'b0;
    drive(2, 32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_hs(2);
    drive(1, 32'h0000_000A, 32'h0000_0003, 1'b1);
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bp_valid_rise", 32'(ok), 1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (k == 5) bus.req_b[2] = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("bp_sum",   bus.rsp_sum,         32'h2345_6789);
      chk("bp_id",    32'(bus.rsp_id),     2);
      chk("bp_cout",  32'(bus.rsp_cout),   0);
      chk("bp_valid", 32'(bus.rsp_valid),  1);
      chk("bp_ready", 32'(bus.req_ready),  0);
    end
    @(posedge clk); #1;
    n0 = rsp_count;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_one_rsp", rsp_count - n0, 1);
    wait_hs(1);
    wait_drain();
    chk("bp_total_rsp", rsp_count - n0, 2);

    // Reset while in HIGH: drop the in-flight op, ptr back to 0.
    drive(2, 32'd7, 32'd9, 1'b0);
    wait_hs(2);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    glog.delete();
    #1;
    chk("midrst_valid", 32'(bus.rsp_valid), 0);
    chk("midrst_ready", 32'(bus.req_ready), 0);
    @(negedge clk);
    chk("midrst_valid_hold", 32'(bus.rsp_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    n0 = rsp_count;
    drive(1, 32'd100, 32'd1, 1'b1);
    drive(3, 32'd200, 32'd2, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (glog.size() >= 1) break;
    end
    bus.req_valid = '0;
    chk("midrst_next_grant", (glog.size() >= 1) ? glog[0] : 99, 1);
    wait_drain();
    chk("midrst_rsp_count", rsp_count - n0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
